// File: rtl/clint.sv
// clint - core-local interrupt/trap sequencer.
//
// Watches the instruction in EX for ECALL/EBREAK/MRET and samples the external
// interrupt lines. When it accepts a request it holds the pipeline, then steps
// through the machine-mode CSR writes one per cycle and ends by issuing a
// one-cycle redirect.
//
// Trap path : IDLE -> W_MEPC -> W_MCAUSE -> W_MSTATUS -> ASSERT -> IDLE
// MRET path : IDLE -> W_MRET -> RET_ASSERT -> IDLE
//
// Ports
//   clk, rst        core clock, synchronous active-high reset
//   int_flag_i      external interrupt request lines (level sensitive)
//   inst_i          instruction in EX, inst_addr_i its PC
//   jump_en_i       EX redirect this cycle, jump_addr_i its target
//   csr_mtvec_i     current mtvec (direct mode only)
//   csr_mepc_i      current mepc
//   csr_mstatus_i   current mstatus (bit 3 MIE, bit 7 MPIE)
//   hold_flag_o     stall request to pipeline control
//   csr_we_o        CSR write strobe, with csr_waddr_o / csr_wdata_o
//   int_assert_o    one-cycle redirect strobe, with target int_addr_o
module clint #(
  parameter int unsigned INT_W     = 8,
  parameter logic [31:0] CAUSE_EXT = 32'h8000_000B
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INT_W-1:0] int_flag_i,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      inst_addr_i,
  input  logic             jump_en_i,
  input  logic [31:0]      jump_addr_i,
  input  logic [31:0]      csr_mtvec_i,
  input  logic [31:0]      csr_mepc_i,
  input  logic [31:0]      csr_mstatus_i,
  output logic             hold_flag_o,
  output logic             csr_we_o,
  output logic [11:0]      csr_waddr_o,
  output logic [31:0]      csr_wdata_o,
  output logic             int_assert_o,
  output logic [31:0]      int_addr_o
);

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MCAUSE,
    W_MSTATUS,
    ASSERT,
    W_MRET,
    RET_ASSERT
  } state_t;

  state_t      state;
  logic [31:0] cause;
  logic [31:0] saved_pc;

  logic        is_ecall;
  logic        is_ebreak;
  logic        is_mret;
  logic        sync_trap;
  logic        async_req;
  logic        accept_trap;
  logic        accept_mret;

  // Request decode and acceptance. Only IDLE accepts; anything arriving while a
  // sequence is running is ignored, so the latched cause/PC stay authoritative.
  always_comb begin
    is_ecall    = (inst_i == INST_ECALL);
    is_ebreak   = (inst_i == INST_EBREAK);
    is_mret     = (inst_i == INST_MRET);
    sync_trap   = is_ecall | is_ebreak;
    async_req   = (|int_flag_i) & csr_mstatus_i[3];
    accept_trap = 1'b0;
    accept_mret = 1'b0;
    if (state == IDLE && !rst) begin
      // ECALL/EBREAK win over MRET, which wins over an async interrupt.
      accept_trap = sync_trap | (~is_mret & async_req);
      accept_mret = ~sync_trap & is_mret;
    end
  end

  // Stall starts in the accepting cycle so the instruction in EX does not retire.
  assign hold_flag_o = (state != IDLE) | accept_trap | accept_mret;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cause    <= '0;
      saved_pc <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept_trap) begin
            state <= W_MEPC;
            if (is_ecall) begin
              cause    <= CAUSE_ECALL;
              saved_pc <= inst_addr_i;
            end else if (is_ebreak) begin
              cause    <= CAUSE_EBREAK;
              saved_pc <= inst_addr_i;
            end else begin
              // An interrupt taken while EX redirects must return to the target.
              cause    <= CAUSE_EXT;
              saved_pc <= jump_en_i ? jump_addr_i : inst_addr_i;
            end
          end else if (accept_mret) begin
            state <= W_MRET;
          end
        end
        W_MEPC:     state <= W_MCAUSE;
        W_MCAUSE:   state <= W_MSTATUS;
        W_MSTATUS:  state <= ASSERT;
        ASSERT:     state <= IDLE;
        W_MRET:     state <= RET_ASSERT;
        RET_ASSERT: state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  // Moore output decode: one CSR write per active write state.
  always_comb begin
    csr_we_o     = 1'b0;
    csr_waddr_o  = '0;
    csr_wdata_o  = '0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;
    unique case (state)
      W_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MEPC;
        csr_wdata_o = saved_pc;
      end
      W_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MCAUSE;
        csr_wdata_o = cause;
      end
      W_MSTATUS: begin
        // MPIE <= MIE, MIE <= 0
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = {csr_mstatus_i[31:8], csr_mstatus_i[3],
                       csr_mstatus_i[6:4], 1'b0, csr_mstatus_i[2:0]};
      end
      ASSERT: begin
        int_assert_o = 1'b1;
        int_addr_o   = csr_mtvec_i & ~32'h3;
      end
      W_MRET: begin
        // MIE <= MPIE, MPIE <= 1
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = {csr_mstatus_i[31:8], 1'b1,
                       csr_mstatus_i[6:4], csr_mstatus_i[7], csr_mstatus_i[2:0]};
      end
      RET_ASSERT: begin
        int_assert_o = 1'b1;
        int_addr_o   = csr_mepc_i;
      end
      default: begin
        csr_we_o = 1'b0;
      end
    endcase
  end

endmodule
